vector_lane_vl: RTL and testbench

- Second-generation vector execution lane: one per lane in the vector unit, driving that lane's register-file slice.
- Adds to the first-generation lane:
  - runtime vector length (vl_i) instead of the fixed vlen_p
  - per-element write masking
  - a start/busy handshake
  - per-element streaming of external write data
  - lane-local reduction sum
- Pipeline is REG -> EX -> WB, one element per cycle.

---
 rtl/vector_lane_vl.sv | 245 ++++++++++++++++++++++++
 tb/tb_vector_lane_vl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_lane_vl.sv
// Second-generation vector execution lane.
// One lane of the vector unit: walks its local elements (e = my_id + lanes*k, e < vl)
// through a REG -> EX -> WB pipeline at one element per cycle, driving this lane's
// register-file slice. Supports ALU ops (vector/vector and vector/scalar), READ,
// streamed WRITE, lane-local REDSUM, per-element write masking and a start/busy/done
// handshake.
// Optional feature: define VECTOR_LANE_SAT_EN to make ADD, SUB and REDSUM use
// unsigned saturating arithmetic instead of wrap-around.
module vector_lane_vl #(
  parameter int vlen_p     = 16,
  parameter int vdw_p      = 8,
  parameter int lanes_p    = 4,
  parameter int op_width_p = 4,
  localparam int addr_w    = $clog2(vlen_p),
  localparam int id_w      = $clog2(lanes_p),
  localparam int vl_w      = $clog2(vlen_p + 1),
  localparam int mw        = vlen_p / lanes_p
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [id_w-1:0]       my_id_i,
  input  logic                  start_i,
  input  logic [op_width_p-1:0] op_i,
  input  logic [vl_w-1:0]       vl_i,
  input  logic [mw-1:0]         mask_i,
  input  logic [vdw_p-1:0]      scalar_i,
  input  logic [vdw_p-1:0]      w_data_i,
  output logic                  w_yumi_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [addr_w-1:0]     r_addr_o,
  input  logic [vdw_p-1:0]      r0_data_i,
  input  logic [vdw_p-1:0]      r1_data_i,
  output logic [vdw_p-1:0]      r_data_o,
  output logic                  v_o,
  output logic [addr_w-1:0]     w_addr_o,
  output logic [vdw_p-1:0]      w_data_o,
  output logic                  w_en_o
);

  localparam int cnt_w = (mw > 1) ? $clog2(mw) : 1;

  localparam logic [op_width_p-1:0] op_alu_lim = op_width_p'(4'b1000);
  localparam logic [op_width_p-1:0] op_read    = op_width_p'(4'b1000);
  localparam logic [op_width_p-1:0] op_write   = op_width_p'(4'b1001);
  localparam logic [op_width_p-1:0] op_redsum  = op_width_p'(4'b1111);

  typedef enum logic [1:0] {
    st_idle,
    st_loop,
    st_drain,
    st_done
  } state_e;

  // Arithmetic helpers shared by the element ALU and the reduction accumulator.
  function automatic logic [vdw_p-1:0] add_f(input logic [vdw_p-1:0] a,
                                             input logic [vdw_p-1:0] b);
`ifdef VECTOR_LANE_SAT_EN
    logic [vdw_p:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[vdw_p] ? {vdw_p{1'b1}} : s[vdw_p-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [vdw_p-1:0] sub_f(input logic [vdw_p-1:0] a,
                                             input logic [vdw_p-1:0] b);
`ifdef VECTOR_LANE_SAT_EN
    return (a < b) ? '0 : a - b;
`else
    return a - b;
`endif
  endfunction

  state_e                  state_q, state_n;
  logic [cnt_w-1:0]        k_q;
  logic [vl_w-1:0]         n_q, n_start;
  logic [op_width_p-1:0]   op_q;
  logic [mw-1:0]           mask_q;
  logic [vdw_p-1:0]        scalar_q;
  logic [id_w-1:0]         id_q;

  logic                    accept, last_k;
  logic                    is_alu, is_read, is_write, is_redsum;

  // REG stage
  logic                    reg_valid;
  logic [addr_w-1:0]       reg_addr;
  logic [vdw_p-1:0]        reg_b;

  // EX stage registers
  logic                    ex_valid_q, ex_mask_q, ex_first_q, ex_last_q;
  logic [addr_w-1:0]       ex_addr_q;
  logic [vdw_p-1:0]        ex_a_q, ex_b_q;

  // EX stage combinational results
  logic [vdw_p-1:0]        alu_res, acc_next, ex_wdata;
  logic [addr_w-1:0]       ex_waddr;
  logic                    ex_wen;

  logic [vdw_p-1:0]        acc_q;
  logic                    wb_last_q;

  assign accept    = start_i && (state_q == st_idle);
  assign last_k    = (vl_w'(k_q) == (n_q - vl_w'(1)));

  assign is_alu    = (op_q < op_alu_lim);
  assign is_read   = (op_q == op_read);
  assign is_write  = (op_q == op_write);
  assign is_redsum = (op_q == op_redsum);

  // Number of local elements for the requested vector length.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    n_start = '0;
    if (vl_i > vl_w'(my_id_i))
      n_start = ((vl_i - vl_w'(my_id_i) - vl_w'(1)) >> id_w) + vl_w'(1);
  end

  // Next-state logic for the op sequencer.
  always_comb begin
    state_n = state_q;
    case (state_q)
      st_idle:  if (accept) state_n = (n_start == '0) ? st_done : st_loop;
      st_loop:  if (last_k) state_n = st_drain;
      st_drain: if (wb_last_q) state_n = st_done;
      st_done:  state_n = st_idle;
      default:  state_n = st_idle;
    endcase
  end

  // State register, element counter and operand latches captured on accept.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!reset_n_i) begin
      state_q  <= st_idle;
      k_q      <= '0;
      n_q      <= '0;
      op_q     <= '0;
      mask_q   <= '0;
      scalar_q <= '0;
      id_q     <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        k_q      <= '0;
        n_q      <= n_start;
        op_q     <= op_i;
        mask_q   <= mask_i;
        scalar_q <= scalar_i;
        id_q     <= my_id_i;
      end else if (state_q == st_loop && !last_k) begin
        k_q <= k_q + cnt_w'(1);
      end
    end
  end

  assign busy_o = (state_q != st_idle);
  assign done_o = (state_q == st_done);

  // REG stage: element k is addressed while the sequencer is in LOOP.
  always_comb begin
    reg_valid = (state_q == st_loop);
    reg_addr  = (addr_w'(k_q) << id_w) | addr_w'(id_q);
    reg_b     = r1_data_i;
    if (is_write)     reg_b = w_data_i;
    else if (op_q[2]) reg_b = scalar_q;
  end

  assign r_addr_o = reg_valid ? reg_addr : '0;
  assign v_o      = reg_valid && is_read;
  assign w_yumi_o = reg_valid && is_write;
  assign r_data_o = r0_data_i;

  // REG -> EX pipeline register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: datapath registers are reset as well so outputs read 0 straight after reset.
    if (!reset_n_i) begin
      ex_valid_q <= 1'b0;
      ex_mask_q  <= 1'b0;
      ex_first_q <= 1'b0;
      ex_last_q  <= 1'b0;
      ex_addr_q  <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
    end else begin
      ex_valid_q <= reg_valid;
      if (reg_valid) begin
        ex_mask_q  <= mask_q[k_q];
        ex_first_q <= (k_q == '0);
        ex_last_q  <= last_k;
        ex_addr_q  <= reg_addr;
        ex_a_q     <= r0_data_i;
        ex_b_q     <= reg_b;
      end
    end
  end

  // EX stage: element ALU, reduction step and write-enable decision.
  always_comb begin
    case (op_q[1:0])
      2'b00:   alu_res = add_f(ex_a_q, ex_b_q);
      2'b01:   alu_res = sub_f(ex_a_q, ex_b_q);
      2'b10:   alu_res = ex_a_q * ex_b_q;
      default: alu_res = ex_a_q & ex_b_q;
    endcase
    if (is_write) alu_res = ex_b_q;

    // Masked elements contribute 0 to the sum; k=0 restarts the accumulator.
    acc_next = add_f(ex_first_q ? '0 : acc_q, ex_mask_q ? ex_a_q : '0);

    ex_wen   = 1'b0;
    ex_wdata = alu_res;
    ex_waddr = ex_addr_q;
    if (is_alu || is_write) begin
      ex_wen = ex_mask_q;
    end else if (is_redsum) begin
      ex_wen   = ex_last_q;
      ex_wdata = acc_next;
      ex_waddr = addr_w'(id_q);
    end
    ex_wen = ex_wen && ex_valid_q;
  end

  // EX -> WB pipeline register; WB values drive the regfile write port directly.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_en_o    <= 1'b0;
      w_addr_o  <= '0;
      w_data_o  <= '0;
      wb_last_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      w_en_o    <= ex_wen;
      wb_last_q <= ex_valid_q && ex_last_q;
      if (ex_wen) begin
        w_addr_o <= ex_waddr;
        w_data_o <= ex_wdata;
      end
      if (ex_valid_q && is_redsum) acc_q <= acc_next;
    end
  end

endmodule

// File: tb/tb_vector_lane_vl.sv
// Testbench for vector_lane_vl (vlen_p=16, lanes_p=4, vdw_p=8).
// A table of operations with hand-computed write streams is replayed cycle by cycle,
// followed by a reset-during-WRITE sequence. Expected values follow VECTOR_LANE_SAT_EN.
module tb_vector_lane_vl;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  my_id_i;
  logic        start_i;
  logic [3:0]  op_i;
  logic [4:0]  vl_i;
  logic [3:0]  mask_i;
  logic [7:0]  scalar_i;
  logic [7:0]  w_data_i;
  logic        w_yumi_o, busy_o, done_o, v_o, w_en_o;
  logic [3:0]  r_addr_o, w_addr_o;
  logic [7:0]  r0_data_i, r1_data_i, r_data_o, w_data_o;

  logic [3:0][7:0] cur_r0, cur_r1;

  always #5 clk_i = ~clk_i;

  // Register-file slice model: element k lives at address id + 4*k, so r_addr[3:2] = k.
  assign r0_data_i = cur_r0[r_addr_o[3:2]];
  assign r1_data_i = cur_r1[r_addr_o[3:2]];
  // Streamed write data is 0xA0 + k for the element currently in REG.
  assign w_data_i  = 8'hA0 + {6'd0, r_addr_o[3:2]};

  vector_lane_vl #(
    .vlen_p(16), .vdw_p(8), .lanes_p(4), .op_width_p(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .my_id_i(my_id_i), .start_i(start_i),
    .op_i(op_i), .vl_i(vl_i), .mask_i(mask_i), .scalar_i(scalar_i),
    .w_data_i(w_data_i), .w_yumi_o(w_yumi_o), .busy_o(busy_o), .done_o(done_o),
    .r_addr_o(r_addr_o), .r0_data_i(r0_data_i), .r1_data_i(r1_data_i),
    .r_data_o(r_data_o), .v_o(v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .w_en_o(w_en_o)
  );

`ifdef VECTOR_LANE_SAT_EN
  localparam logic [7:0] sub_exp = 8'd0;
  localparam logic [7:0] add_k0  = 8'd255;
  localparam logic [7:0] add_k2  = 8'd255;
`else
  localparam logic [7:0] sub_exp = 8'd253;
  localparam logic [7:0] add_k0  = 8'd44;
  localparam logic [7:0] add_k2  = 8'd0;
`endif

  typedef struct {
    string           name;
    logic [3:0]      op;
    logic [1:0]      id;
    logic [4:0]      vl;
    int              n;       // local element count
    logic [3:0]      mask;
    logic [7:0]      scalar;
    logic [3:0][7:0] r0v;     // r0 value of element k
    logic [3:0][7:0] r1v;
    logic [3:0]      wen;     // bit s: write expected at t+3+s
    logic [3:0][3:0] waddr;
    logic [3:0][7:0] wdata;
    bit              poke;    // pulse start_i while busy
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [1:0] id,
                              input logic [4:0] vl, input int n, input logic [3:0] mask,
                              input logic [7:0] scalar, input logic [31:0] r0v,
                              input logic [31:0] r1v, input logic [3:0] wen,
                              input logic [15:0] waddr, input logic [31:0] wdata,
                              input bit poke);
    vec_t v;
    v.name = name; v.op = op; v.id = id; v.vl = vl; v.n = n; v.mask = mask;
    v.scalar = scalar; v.r0v = r0v; v.r1v = r1v; v.wen = wen; v.waddr = waddr;
    v.wdata = wdata; v.poke = poke;
    return v;
  endfunction

  // Issue one op at cycle t and check every output from t+1 to one cycle past done.
  task automatic run_vec(input vec_t v);
    int last_c;
    int slot;
    logic exp_v, exp_y, exp_w;
    logic [3:0] exp_ra;
    cur_r0 = v.r0v;
    cur_r1 = v.r1v;
    @(negedge clk_i);
    check($sformatf("%s idle busy", v.name), busy_o, 0);
    op_i = v.op; my_id_i = v.id; vl_i = v.vl; mask_i = v.mask; scalar_i = v.scalar;
    start_i = 1'b1;
    last_c = (v.n == 0) ? 1 : v.n + 3;
    for (int c = 1; c <= last_c + 1; c++) begin
      @(negedge clk_i);
      if (c == 1) start_i = 1'b0;
      exp_v  = (v.op == 4'b1000) && (c <= v.n);
      exp_y  = (v.op == 4'b1001) && (c <= v.n);
      exp_ra = (c <= v.n) ? 4'(v.id) + 4'(4 * (c - 1)) : 4'd0;
      slot   = c - 3;
      exp_w  = (slot >= 0 && slot < 4) ? v.wen[slot] : 1'b0;
      check($sformatf("%s busy c%0d", v.name, c), busy_o, (c <= last_c));
      check($sformatf("%s done c%0d", v.name, c), done_o, (c == last_c));
      check($sformatf("%s v_o c%0d", v.name, c), v_o, exp_v);
      check($sformatf("%s yumi c%0d", v.name, c), w_yumi_o, exp_y);
      check($sformatf("%s r_addr c%0d", v.name, c), r_addr_o, exp_ra);
      if (exp_v) check($sformatf("%s r_data c%0d", v.name, c), r_data_o, v.r0v[c-1]);
      check($sformatf("%s w_en c%0d", v.name, c), w_en_o, exp_w);
      if (exp_w) begin
        check($sformatf("%s w_addr c%0d", v.name, c), w_addr_o, v.waddr[slot]);
        check($sformatf("%s w_data c%0d", v.name, c), w_data_o, v.wdata[slot]);
      end
      if (v.poke && c == 2) begin
        start_i = 1'b1; op_i = 4'b0000; vl_i = 5'd16; mask_i = 4'hF;
      end
      if (v.poke && c == 3) start_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0; start_i = 1'b0; op_i = '0; my_id_i = '0; vl_i = '0;
    mask_i = '0; scalar_i = '0; cur_r0 = '0; cur_r1 = '0;

    //        name        op       id  vl  n  mask     scalar  r0v (k3..k0)                    r1v                             wen      waddr                        wdata                                  poke
    vq.push_back(mk("add_id1",  4'b0000, 1, 10, 3, 4'b1111, 8'd0,  {8'd6,8'd5,8'd4,8'd3},         {8'd6,8'd5,8'd4,8'd3},         4'b0111, {4'd0,4'd9,4'd5,4'd1},       {8'd0,8'd10,8'd8,8'd6},                0));
    vq.push_back(mk("add_n0",   4'b0000, 1, 1,  0, 4'b1111, 8'd0,  {8'd6,8'd5,8'd4,8'd3},         {8'd6,8'd5,8'd4,8'd3},         4'b0000, 16'd0,                       32'd0,                                 0));
    vq.push_back(mk("add_id0",  4'b0000, 0, 16, 4, 4'b1111, 8'd0,  {8'd6,8'd5,8'd4,8'd3},         {8'd6,8'd5,8'd4,8'd3},         4'b1111, {4'd12,4'd8,4'd4,4'd0},      {8'd12,8'd10,8'd8,8'd6},               0));
    vq.push_back(mk("subs",     4'b0101, 0, 16, 4, 4'b0101, 8'd5,  {8'd2,8'd2,8'd2,8'd2},         32'hFFFF_FFFF,                 4'b0101, {4'd0,4'd8,4'd0,4'd0},       {8'd0,sub_exp,8'd0,sub_exp},           0));
    vq.push_back(mk("redsum",   4'b1111, 2, 16, 4, 4'b1011, 8'd0,  {8'd1,8'd60,8'd100,8'd100},    32'd0,                         4'b1000, {4'd2,4'd0,4'd0,4'd0},       {8'd201,8'd0,8'd0,8'd0},               0));
    vq.push_back(mk("read",     4'b1000, 3, 16, 4, 4'b0000, 8'd0,  {8'h44,8'h33,8'h22,8'h11},     32'd0,                         4'b0000, 16'd0,                       32'd0,                                 1));
    vq.push_back(mk("write",    4'b1001, 2, 16, 4, 4'b1101, 8'd0,  32'd0,                         32'd0,                         4'b1101, {4'd14,4'd10,4'd0,4'd2},     {8'hA3,8'hA2,8'h00,8'hA0},             0));
    vq.push_back(mk("mul",      4'b0010, 0, 7,  2, 4'b1111, 8'd0,  {8'd0,8'd0,8'd20,8'd20},       {8'd0,8'd0,8'd13,8'd3},        4'b0011, {4'd0,4'd0,4'd4,4'd0},       {8'd0,8'd0,8'd4,8'd60},                0));
    vq.push_back(mk("ands_n1",  4'b0111, 3, 4,  1, 4'b1111, 8'h3C, {8'd0,8'd0,8'd0,8'hF0},        32'd0,                         4'b0001, {4'd0,4'd0,4'd0,4'd3},       {8'd0,8'd0,8'd0,8'h30},                0));
    vq.push_back(mk("nop",      4'b1010, 0, 16, 4, 4'b1111, 8'd0,  {8'd9,8'd9,8'd9,8'd9},         {8'd9,8'd9,8'd9,8'd9},         4'b0000, 16'd0,                       32'd0,                                 0));
    vq.push_back(mk("add_wrap", 4'b0000, 0, 16, 4, 4'b1111, 8'd0,  {8'd200,8'd200,8'd200,8'd200}, {8'd0,8'd56,8'd55,8'd100},     4'b1111, {4'd12,4'd8,4'd4,4'd0},      {8'd200,add_k2,8'd255,add_k0},         0));
    vq.push_back(mk("red_vl0",  4'b1111, 0, 0,  0, 4'b1111, 8'd0,  {8'd5,8'd5,8'd5,8'd5},         32'd0,                         4'b0000, 16'd0,                       32'd0,                                 0));
    vq.push_back(mk("red_vl15", 4'b1111, 3, 15, 3, 4'b1111, 8'd0,  {8'h77,8'd3,8'd2,8'd1},        32'd0,                         4'b0100, {4'd0,4'd3,4'd0,4'd0},       {8'd0,8'd6,8'd0,8'd0},                 0));

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst v_o", v_o, 0);
    check("rst w_en", w_en_o, 0);
    check("rst yumi", w_yumi_o, 0);
    check("rst r_addr", r_addr_o, 0);
    check("rst w_addr", w_addr_o, 0);
    check("rst w_data", w_data_o, 0);
    reset_n_i = 1'b1;

    foreach (vq[i]) run_vec(vq[i]);

    // WRITE interrupted by reset in the first WB cycle (t+3).
    @(negedge clk_i);
    op_i = 4'b1001; my_id_i = 2'd0; vl_i = 5'd16; mask_i = 4'hF; start_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    check("rstw w_en t3", w_en_o, 1);
    check("rstw w_data t3", w_data_o, 8'hA0);
    reset_n_i = 1'b0;
    #1;
    check("rstw busy", busy_o, 0);
    check("rstw done", done_o, 0);
    check("rstw v_o", v_o, 0);
    check("rstw w_en", w_en_o, 0);
    check("rstw yumi", w_yumi_o, 0);
    check("rstw r_addr", r_addr_o, 0);
    check("rstw w_addr", w_addr_o, 0);
    check("rstw w_data", w_data_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("rstw idle w_en %0d", c), w_en_o, 0);
      check($sformatf("rstw idle busy %0d", c), busy_o, 0);
    end

    // Normal operation after reset.
    run_vec(vq[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
